freq_meter_mc: RTL and testbench
================================

FREQ_METER_MC -- requirements
Module: freq_meter_mc

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, range 1..16.
REQ-002 Parameter CNT_W, default 32: width of each edge counter and result word.
REQ-003 Parameter GATE_W, default 32: width of the gate-length value.
REQ-004 clk_clk  in  1  single system clock; all logic SHALL be synchronous to its rising edge.
REQ-005 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-006 sig_in  in  CHANNELS  asynchronous measured signals, one bit per channel.
REQ-007 gate_len  in  GATE_W  gate window length in clk_clk cycles.
REQ-008 start  in  1  high = continuous measurement enabled.
REQ-009 freq_export  out  CNT_W  reported edge count for the channel on freq_ch.
REQ-010 freq_ch  out  max(1,clog2(CHANNELS))  channel index of freq_export.
REQ-011 freq_en_export  out  1  result valid.
REQ-012 freq_ack  in  1  consumer accepts the current result.
REQ-013 busy  out  1  high while a gate window is running.
REQ-014 ovf  out  CHANNELS  per-channel saturation flags for the presented snapshot.
REQ-015 overrun  out  1  sticky flag: a snapshot was dropped.

Function
REQ-016 Each sig_in bit SHALL pass through a 2-FF synchroniser and a rising-edge detector; a sig_in rise is counted 3 cycles later.
REQ-017 Gate FSM states SHALL be IDLE, GATE and LATCH.
REQ-018 IDLE -> GATE when start=1; gate_len SHALL be sampled on entry into GATE, and gate_len=0 SHALL be treated as 1.
REQ-019 GATE SHALL last exactly the sampled number of cycles; busy=1 throughout GATE.
REQ-020 On the last GATE cycle the FSM SHALL enter LATCH for one cycle; that cycle SHALL copy all counters, including any edge detected in that cycle, to a snapshot buffer and clear the counters.
REQ-021 LATCH -> GATE if start=1, otherwise LATCH -> IDLE.
REQ-022 An edge detected in the LATCH cycle SHALL count in the next window, so no edge is lost between windows.
REQ-023 Counters SHALL saturate at 2^CNT_W-1; at saturation the channel's ovf bit SHALL be set in the snapshot.
REQ-024 start=0 during GATE SHALL abort the window: go to IDLE the next cycle, clear the counters, and produce no snapshot.
REQ-025 The report FSM SHALL have states RIDLE and RSEND. A new snapshot moves RIDLE -> RSEND with freq_ch=0.
REQ-026 In RSEND, freq_en_export=1, and freq_export, freq_ch and ovf SHALL stay stable until a cycle with freq_ack=1.
REQ-027 A cycle with freq_ack=1 in RSEND SHALL advance to channel +1 on the next cycle; after channel CHANNELS-1 the FSM SHALL return to RIDLE with freq_en_export=0.
REQ-028 freq_ack while freq_en_export=0 SHALL be ignored.
REQ-029 If LATCH occurs while the report FSM is in RSEND, the new snapshot SHALL be dropped, overrun SHALL be set, and the current report SHALL continue unchanged.
REQ-030 overrun SHALL clear on the first cycle start=0 is sampled while the gate FSM is in IDLE.
REQ-031 A report in progress SHALL complete regardless of start.

Reset
REQ-032 While reset_reset_n=0, the following SHALL hold: both FSMs idle; counters, snapshot and synchronisers zero; freq_export=0, freq_ch=0, freq_en_export=0, busy=0, ovf=0, overrun=0.
REQ-033 Reset asserted mid-gate or mid-report SHALL discard all data; no result appears after release.
REQ-034 The first GATE entry after release requires start=1 sampled on a clock edge.

Verification
REQ-035 CHANNELS=4, gate_len=100, start=1, channel k toggling with period 2*(k+1) cycles, freq_ack tied high -> four results of about 50/25/17/13 edges (±1), freq_ch 0..3 in order.
REQ-036 freq_ack held low for 20 cycles in RSEND -> freq_en_export=1 and freq_export/freq_ch unchanged for all 20 cycles; the result advances exactly one cycle after the ack.
REQ-037 CNT_W=4, 30 edges on channel 0 in one gate -> freq_export=15 with ovf[0]=1; other channels have ovf=0.
REQ-038 gate_len=10, freq_ack=0 for 30 cycles -> overrun=1 and the first snapshot's values are still reported; start=0 in IDLE -> overrun=0.
REQ-039 gate_len=0 -> one-cycle GATE and busy pulses for 1 cycle; start=0 mid-gate -> IDLE, no freq_en_export.
REQ-040 Reset pulse during RSEND -> freq_en_export=0 the same cycle via the asynchronous path; all outputs zero; no stale result after release.

Source files
------------

// File: rtl/freq_meter_mc_if.sv
// Result-reporting channel of the multi-channel frequency meter.
// The meter drives one channel result at a time; the consumer acknowledges it.
interface freq_meter_mc_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CNT_W-1:0]    freq_export;
    logic [CH_W-1:0]     freq_ch;
    logic                freq_en_export;
    logic                freq_ack;
    logic [CHANNELS-1:0] ovf;

    modport master (
        output freq_export, freq_ch, freq_en_export, ovf,
        input  freq_ack
    );

    modport slave (
        input  freq_export, freq_ch, freq_en_export, ovf,
        output freq_ack
    );
endinterface

// File: rtl/freq_meter_mc.sv
// Multi-channel gated edge counter: counts synchronised rising edges per channel
// over a gate window, snapshots the counts and reports them one channel at a time.
module freq_meter_mc #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32,
    parameter int GATE_W   = 32
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [CHANNELS-1:0] sig_in,
    input  logic [GATE_W-1:0]   gate_len,
    input  logic                start,
    output logic                busy,
    output logic                overrun,
    freq_meter_mc_if.master     rpt
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GATE  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_SEND = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0] sync1_q, sync2_q, sync3_q;
    logic [CHANNELS-1:0] rise;

    logic [1:0]          gst_q, gst_d;
    logic [GATE_W-1:0]   gcnt_q, gcnt_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_inc [CHANNELS];
    logic [CNT_W-1:0]    snap_q [CHANNELS];
    logic [CNT_W-1:0]    snap_d [CHANNELS];
    logic [CHANNELS-1:0] snap_ovf_q, snap_ovf_d;
    logic                rpt_st_q, rpt_st_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                overrun_q, overrun_d;

    logic                latch_now;
    logic                cnt_clr;
    logic                cnt_run;
    logic [GATE_W-1:0]   gate_load;

    assign rise      = sync2_q & ~sync3_q;
    assign gate_load = (gate_len == '0) ? GATE_W'(1) : gate_len;

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_inc[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(rise[i]);
        end
    end

    always_comb begin
        gst_d      = gst_q;
        gcnt_d     = gcnt_q;
        snap_d     = snap_q;
        snap_ovf_d = snap_ovf_q;
        rpt_st_d   = rpt_st_q;
        ch_d       = ch_q;
        overrun_d  = overrun_q;
        latch_now  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_run    = 1'b0;

        case (gst_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (start) begin
                    gst_d  = S_GATE;
                    gcnt_d = gate_load;
                end else begin
                    overrun_d = 1'b0;
                end
            end
            S_GATE: begin
                if (!start) begin
                    gst_d   = S_IDLE;
                    cnt_clr = 1'b1;
                end else if (gcnt_q == GATE_W'(1)) begin
                    // Snapshot takes cnt_inc so an edge in the final gate cycle is kept.
                    gst_d     = S_LATCH;
                    latch_now = 1'b1;
                    cnt_clr   = 1'b1;
                end else begin
                    gcnt_d  = gcnt_q - GATE_W'(1);
                    cnt_run = 1'b1;
                end
            end
            S_LATCH: begin
                // Edges seen here already belong to the following window.
                cnt_run = 1'b1;
                if (start) begin
                    gst_d  = S_GATE;
                    gcnt_d = gate_load;
                end else begin
                    gst_d = S_IDLE;
                end
            end
            default: begin
                gst_d   = S_IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_clr ? '0 : (cnt_run ? cnt_inc[i] : cnt_q[i]);
        end

        case (rpt_st_q)
            R_IDLE: begin
                if (latch_now) begin
                    rpt_st_d = R_SEND;
                    ch_d     = '0;
                    for (int unsigned i = 0; i < CHANNELS; i++) begin
                        snap_d[i]     = cnt_inc[i];
                        snap_ovf_d[i] = (cnt_inc[i] == CNT_MAX);
                    end
                end
            end
            default: begin
                if (latch_now) begin
                    overrun_d = 1'b1;
                end
                if (rpt.freq_ack) begin
                    if (ch_q == CH_W'(CHANNELS - 1)) begin
                        rpt_st_d = R_IDLE;
                        ch_d     = '0;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            gst_q      <= S_IDLE;
            gcnt_q     <= '0;
            snap_ovf_q <= '0;
            rpt_st_q   <= R_IDLE;
            ch_q       <= '0;
            overrun_q  <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sig_in;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            gst_q      <= gst_d;
            gcnt_q     <= gcnt_d;
            snap_ovf_q <= snap_ovf_d;
            rpt_st_q   <= rpt_st_d;
            ch_q       <= ch_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
        end
    end

    assign busy               = (gst_q == S_GATE);
    assign overrun            = overrun_q;
    assign rpt.freq_en_export = (rpt_st_q == R_SEND);
    assign rpt.freq_ch        = ch_q;
    assign rpt.freq_export    = (rpt_st_q == R_SEND) ? snap_q[ch_q] : '0;
    assign rpt.ovf            = (rpt_st_q == R_SEND) ? snap_ovf_q : '0;
endmodule

// File: tb/tb_freq_meter_mc.sv
// Scoreboard bench for freq_meter_mc: a 32-bit-counter instance for most scenarios
// and a 4-bit-counter instance for saturation.
module tb_freq_meter_mc;
    logic        clk;
    logic        rst_n;
    logic [3:0]  sig;
    logic [31:0] gate_len;
    logic        start_m, start_s;
    logic        busy_m, busy_s;
    logic        ovr_m, ovr_s;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          dut;
        int          ch;
        int unsigned lo;
        int unsigned hi;
        logic [3:0]  ovf;
    } exp_t;

    exp_t sb[$];

    freq_meter_mc_if #(.CHANNELS(4), .CNT_W(32)) m_if ();
    freq_meter_mc_if #(.CHANNELS(4), .CNT_W(4))  s_if ();

    freq_meter_mc #(.CHANNELS(4), .CNT_W(32), .GATE_W(32)) u_main (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sig_in        (sig),
        .gate_len      (gate_len),
        .start         (start_m),
        .busy          (busy_m),
        .overrun       (ovr_m),
        .rpt           (m_if)
    );

    freq_meter_mc #(.CHANNELS(4), .CNT_W(4), .GATE_W(32)) u_small (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sig_in        (sig),
        .gate_len      (gate_len),
        .start         (start_s),
        .busy          (busy_s),
        .overrun       (ovr_s),
        .rpt           (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int dut, input int ch, input int unsigned lo,
                            input int unsigned hi, input logic [3:0] ovf);
        exp_t e;
        e.dut = dut; e.ch = ch; e.lo = lo; e.hi = hi; e.ovf = ovf;
        sb.push_back(e);
    endtask

    function automatic logic cur(input int sel);
        case (sel)
            0:       return busy_m;
            1:       return m_if.freq_en_export;
            2:       return busy_s;
            default: return s_if.freq_en_export;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic lvl, input int budget, input string what);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cur(sel) == lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got no level %0d within %0d cycles required it", what, lvl, budget);
        end
    endtask

    task automatic pulse_train(input int n0, input int n1, input int n2, input int n3);
        int mx;
        mx = n0;
        if (n1 > mx) mx = n1;
        if (n2 > mx) mx = n2;
        if (n3 > mx) mx = n3;
        for (int p = 0; p < mx; p++) begin
            sig = {logic'(p < n3), logic'(p < n2), logic'(p < n1), logic'(p < n0)};
            tick();
            sig = '0;
            tick();
        end
    endtask

    task automatic check_result(input int dut, input int ch, input logic [31:0] val,
                                input logic [3:0] ovf);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got dut%0d ch=%0d val=%0d required no result", dut, ch, val);
            return;
        end
        e = sb.pop_front();
        if (e.dut != dut || e.ch != ch || val < e.lo || val > e.hi || ovf !== e.ovf) begin
            errors++;
            $display("FAIL result: got dut%0d ch=%0d val=%0d ovf=%b required dut%0d ch=%0d val=%0d..%0d ovf=%b",
                     dut, ch, val, ovf, e.dut, e.ch, e.lo, e.hi, e.ovf);
        end
    endtask

    // Monitor: a result is consumed on every cycle where valid and ack are both high.
    always begin
        @(negedge clk);
        #1;
        if (m_if.freq_en_export && m_if.freq_ack)
            check_result(0, int'(m_if.freq_ch), m_if.freq_export, m_if.ovf);
        if (s_if.freq_en_export && s_if.freq_ack)
            check_result(1, int'(s_if.freq_ch), {28'd0, s_if.freq_export}, s_if.ovf);
    end

    initial begin
        logic started;
        logic done;
        logic seen;

        rst_n         = 1'b0;
        sig           = '0;
        gate_len      = 32'd0;
        start_m       = 1'b0;
        start_s       = 1'b0;
        m_if.freq_ack = 1'b0;
        s_if.freq_ack = 1'b0;
        tick();
        tick();

        chk("rst_en",      32'(m_if.freq_en_export), 32'd0);
        chk("rst_export",  m_if.freq_export, 32'd0);
        chk("rst_ch",      32'(m_if.freq_ch), 32'd0);
        chk("rst_ovf",     32'(m_if.ovf), 32'd0);
        chk("rst_busy",    32'(busy_m), 32'd0);
        chk("rst_overrun", 32'(ovr_m), 32'd0);
        chk("rst_en_s",    32'(s_if.freq_en_export), 32'd0);

        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_without_start", 32'(busy_m), 32'd0);

        // Toggling channels, ack tied high, one 100-cycle window.
        push_exp(0, 0, 49, 51, 4'b0);
        push_exp(0, 1, 24, 26, 4'b0);
        push_exp(0, 2, 16, 18, 4'b0);
        push_exp(0, 3, 12, 14, 4'b0);
        m_if.freq_ack = 1'b1;
        gate_len      = 32'd100;
        start_m       = 1'b1;
        started       = 1'b0;
        done          = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++) sig[k] = logic'((c / (k + 1)) % 2);
            tick();
            if (busy_m) started = 1'b1;
            else if (started) begin
                done = 1'b1;
                break;
            end
        end
        start_m = 1'b0;
        sig     = '0;
        chk("toggle_window_done", 32'(done), 32'd1);
        wait_sig(1, 1'b0, 20, "toggle_report_end");

        // Held result while ack is low, then one channel per acked cycle.
        m_if.freq_ack = 1'b0;
        push_exp(0, 0, 3, 3, 4'b0);
        push_exp(0, 1, 1, 1, 4'b0);
        push_exp(0, 2, 0, 0, 4'b0);
        push_exp(0, 3, 5, 5, 4'b0);
        gate_len = 32'd20;
        start_m  = 1'b1;
        wait_sig(0, 1'b1, 10, "hold_busy");
        pulse_train(3, 1, 0, 5);
        wait_sig(0, 1'b0, 30, "hold_latch");
        start_m = 1'b0;
        wait_sig(1, 1'b1, 10, "hold_valid");
        for (int i = 0; i < 20; i++) begin
            chk("hold_en",     32'(m_if.freq_en_export), 32'd1);
            chk("hold_ch",     32'(m_if.freq_ch), 32'd0);
            chk("hold_export", m_if.freq_export, 32'd3);
            tick();
        end
        m_if.freq_ack = 1'b1;
        wait_sig(1, 1'b0, 20, "hold_report_end");
        m_if.freq_ack = 1'b0;

        // Saturation on the 4-bit instance.
        s_if.freq_ack = 1'b1;
        push_exp(1, 0, 15, 15, 4'b0001);
        push_exp(1, 1, 0, 0, 4'b0001);
        push_exp(1, 2, 0, 0, 4'b0001);
        push_exp(1, 3, 0, 0, 4'b0001);
        gate_len = 32'd70;
        start_s  = 1'b1;
        wait_sig(2, 1'b1, 10, "sat_busy");
        pulse_train(30, 0, 0, 0);
        wait_sig(2, 1'b0, 30, "sat_latch");
        start_s = 1'b0;
        wait_sig(3, 1'b1, 10, "sat_valid");
        wait_sig(3, 1'b0, 20, "sat_report_end");
        s_if.freq_ack = 1'b0;

        // Overrun: continuous 10-cycle windows while the first report is stalled.
        push_exp(0, 0, 2, 2, 4'b0);
        push_exp(0, 1, 0, 0, 4'b0);
        push_exp(0, 2, 0, 0, 4'b0);
        push_exp(0, 3, 0, 0, 4'b0);
        gate_len = 32'd10;
        start_m  = 1'b1;
        wait_sig(0, 1'b1, 10, "ovr_busy");
        pulse_train(2, 0, 0, 0);
        wait_sig(1, 1'b1, 30, "ovr_valid");
        repeat (30) tick();
        chk("overrun_set",      32'(ovr_m), 32'd1);
        chk("overrun_keep_ch",  32'(m_if.freq_ch), 32'd0);
        chk("overrun_keep_val", m_if.freq_export, 32'd2);
        start_m = 1'b0;
        repeat (3) tick();
        chk("overrun_clear",    32'(ovr_m), 32'd0);
        chk("overrun_idle",     32'(busy_m), 32'd0);
        chk("report_continues", 32'(m_if.freq_en_export), 32'd1);
        m_if.freq_ack = 1'b1;
        wait_sig(1, 1'b0, 20, "ovr_report_end");

        // gate_len=0: single-cycle gate; ack already high while idle.
        push_exp(0, 0, 0, 0, 4'b0);
        push_exp(0, 1, 0, 0, 4'b0);
        push_exp(0, 2, 0, 0, 4'b0);
        push_exp(0, 3, 0, 0, 4'b0);
        gate_len = 32'd0;
        start_m  = 1'b1;
        tick();
        chk("gate0_busy_on",  32'(busy_m), 32'd1);
        tick();
        chk("gate0_busy_off", 32'(busy_m), 32'd0);
        start_m = 1'b0;
        wait_sig(1, 1'b1, 10, "gate0_valid");
        wait_sig(1, 1'b0, 20, "gate0_report_end");

        // Abort mid-gate: no result, and the counters start clean afterwards.
        m_if.freq_ack = 1'b0;
        gate_len = 32'd20;
        start_m  = 1'b1;
        wait_sig(0, 1'b1, 10, "abort_busy");
        pulse_train(0, 1, 0, 0);
        repeat (3) tick();
        start_m = 1'b0;
        tick();
        chk("abort_busy_off", 32'(busy_m), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_if.freq_en_export) seen = 1'b1;
            tick();
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        push_exp(0, 0, 0, 0, 4'b0);
        push_exp(0, 1, 0, 0, 4'b0);
        push_exp(0, 2, 0, 0, 4'b0);
        push_exp(0, 3, 0, 0, 4'b0);
        m_if.freq_ack = 1'b1;
        gate_len = 32'd10;
        start_m  = 1'b1;
        wait_sig(0, 1'b1, 10, "clean_busy");
        wait_sig(0, 1'b0, 20, "clean_latch");
        start_m = 1'b0;
        wait_sig(1, 1'b1, 10, "clean_valid");
        wait_sig(1, 1'b0, 20, "clean_report_end");

        // Asynchronous reset in the middle of a report.
        m_if.freq_ack = 1'b0;
        gate_len = 32'd5;
        start_m  = 1'b1;
        wait_sig(0, 1'b1, 10, "arst_busy");
        wait_sig(0, 1'b0, 20, "arst_latch");
        start_m = 1'b0;
        wait_sig(1, 1'b1, 10, "arst_valid");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en",      32'(m_if.freq_en_export), 32'd0);
        chk("arst_export",  m_if.freq_export, 32'd0);
        chk("arst_ch",      32'(m_if.freq_ch), 32'd0);
        chk("arst_ovf",     32'(m_if.ovf), 32'd0);
        chk("arst_busy",    32'(busy_m), 32'd0);
        chk("arst_overrun", 32'(ovr_m), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        m_if.freq_ack = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_if.freq_en_export) seen = 1'b1;
            tick();
        end
        chk("arst_no_stale", 32'(seen), 32'd0);

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
